fire_trigger_conditioner: RTL and testbench

- Upstream of the laser driver: turns raw active-low fire and reload buttons into clean, rate-limited, ammo-gated active-low fire pulses on fire_n, which drives the laser driver's `in` input.
- Per button: 2-flop synchronizer, debounce, falling-edge (press) detect.
- Limits shots to a magazine count and enforces a minimum gap between shots, so no press is consumed by the ammo count while the laser driver is in its 4 s on/cooldown window.
- Provides a timed reload.

---
 rtl/fire_trigger_conditioner.sv | 137 +++++++++++++
 tb/tb_fire_trigger_conditioner.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fire_trigger_conditioner.sv
// Turns bouncy active-low fire/reload buttons into clean, ammo-gated, rate-limited active-low fire pulses.
// Latency: fire_n falls one cycle after the debounced press strobe. Presses arriving while busy are dropped.
module fire_trigger_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned PULSE_CYCLES    = 16,
   parameter int unsigned GAP_CYCLES      = 200000000,
   parameter int unsigned AMMO_MAX        = 8,
   parameter int unsigned RELOAD_CYCLES   = 150000000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       button_n,
   input  logic       reload_n,
   output logic       fire_n,
   output logic [3:0] ammo,
   output logic       busy,
   output logic       empty
);

   localparam logic [31:0] DEB_LAST   = 32'(DEBOUNCE_CYCLES - 1);
   localparam logic [31:0] PULSE_LAST = 32'(PULSE_CYCLES - 1);
   localparam logic [31:0] GAP_LAST   = 32'(GAP_CYCLES - 1);
   localparam logic [31:0] REL_LAST   = 32'(RELOAD_CYCLES - 1);
   localparam logic [3:0]  AMMO_FULL  = 4'(AMMO_MAX);

   typedef enum logic [1:0] {IDLE, FIRE, GAP, RELOAD} state_t;

   state_t      state_q, state_d;
   logic [1:0]  btn_sync_q, rld_sync_q;
   logic        btn_db_q, btn_db_d, btn_prev_q;
   logic        rld_db_q, rld_db_d, rld_prev_q;
   logic [31:0] btn_deb_q, btn_deb_d, rld_deb_q, rld_deb_d;
   logic [31:0] tmr_q, tmr_d, rel_q, rel_d;
   logic [3:0]  ammo_q, ammo_d;
   logic        fire_n_q, fire_n_d;
   logic        busy_q, empty_q;
   logic        fire_press, reload_press;

   // A level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_comb begin
      btn_db_d  = btn_db_q;
      btn_deb_d = '0;
      if (btn_sync_q[1] != btn_db_q) begin
         if (btn_deb_q == DEB_LAST) btn_db_d = btn_sync_q[1];
         else                       btn_deb_d = btn_deb_q + 32'd1;
      end
      rld_db_d  = rld_db_q;
      rld_deb_d = '0;
      if (rld_sync_q[1] != rld_db_q) begin
         if (rld_deb_q == DEB_LAST) rld_db_d = rld_sync_q[1];
         else                       rld_deb_d = rld_deb_q + 32'd1;
      end
   end

   assign fire_press   = btn_prev_q & ~btn_db_q;
   assign reload_press = rld_prev_q & ~rld_db_q;

   always_comb begin
      state_d  = state_q;
      ammo_d   = ammo_q;
      fire_n_d = 1'b1;
      tmr_d    = tmr_q;
      rel_d    = rel_q;
      case (state_q)
         IDLE: begin
            if (fire_press && ammo_q != 4'd0) begin
               state_d  = FIRE;
               ammo_d   = ammo_q - 4'd1;
               tmr_d    = '0;
               fire_n_d = 1'b0;
            end else if (reload_press && ammo_q != AMMO_FULL) begin
               state_d = RELOAD;
               rel_d   = '0;
            end
         end
         FIRE: begin
            tmr_d = tmr_q + 32'd1;
            if (tmr_q == PULSE_LAST) state_d = (tmr_q == GAP_LAST) ? IDLE : GAP;
            else                     fire_n_d = 1'b0;
         end
         GAP: begin
            tmr_d = tmr_q + 32'd1;
            if (tmr_q == GAP_LAST) state_d = IDLE;
         end
         RELOAD: begin
            rel_d = rel_q + 32'd1;
            if (rel_q == REL_LAST) begin
               state_d = IDLE;
               ammo_d  = AMMO_FULL;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         btn_sync_q <= 2'b11;
         rld_sync_q <= 2'b11;
         btn_db_q   <= 1'b1;
         btn_prev_q <= 1'b1;
         rld_db_q   <= 1'b1;
         rld_prev_q <= 1'b1;
         btn_deb_q  <= '0;
         rld_deb_q  <= '0;
         tmr_q      <= '0;
         rel_q      <= '0;
         ammo_q     <= AMMO_FULL;
         fire_n_q   <= 1'b1;
         busy_q     <= 1'b0;
         empty_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         btn_sync_q <= {btn_sync_q[0], button_n};
         rld_sync_q <= {rld_sync_q[0], reload_n};
         btn_db_q   <= btn_db_d;
         btn_prev_q <= btn_db_q;
         rld_db_q   <= rld_db_d;
         rld_prev_q <= rld_db_q;
         btn_deb_q  <= btn_deb_d;
         rld_deb_q  <= rld_deb_d;
         tmr_q      <= tmr_d;
         rel_q      <= rel_d;
         ammo_q     <= ammo_d;
         fire_n_q   <= fire_n_d;
         busy_q     <= (state_d != IDLE);
         empty_q    <= (ammo_d == 4'd0);
      end
   end

   assign fire_n = fire_n_q;
   assign ammo   = ammo_q;
   assign busy   = busy_q;
   assign empty  = empty_q;

endmodule

// File: tb/tb_fire_trigger_conditioner.sv
// Directed bench for fire_trigger_conditioner with small timing parameters.
module tb_fire_trigger_conditioner;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       button_n = 1'b1;
   logic       reload_n = 1'b1;
   logic       fire_n;
   logic [3:0] ammo;
   logic       busy;
   logic       empty;

   int n_cmp = 0;
   int n_err = 0;
   int falls, lows, busys;
   logic prev_fire;

   fire_trigger_conditioner #(
      .DEBOUNCE_CYCLES(4),
      .PULSE_CYCLES(3),
      .GAP_CYCLES(10),
      .AMMO_MAX(2),
      .RELOAD_CYCLES(8)
   ) dut (
      .clock(clock),
      .reset(reset),
      .button_n(button_n),
      .reload_n(reload_n),
      .fire_n(fire_n),
      .ammo(ammo),
      .busy(busy),
      .empty(empty)
   );

   always #5 clock = ~clock;

   // Observation: count pulses, low cycles and busy cycles, sampled on the falling edge.
   task automatic clear_watch();
      falls = 0;
      lows = 0;
      busys = 0;
      prev_fire = fire_n;
   endtask

   task automatic watch(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         if (fire_n === 1'b0) begin
            lows++;
            if (prev_fire === 1'b1) falls++;
         end
         if (busy === 1'b1) busys++;
         prev_fire = fire_n;
      end
   endtask

   task automatic press_fire(input int n);
      button_n = 1'b0;
      watch(n);
      button_n = 1'b1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      button_n = 1'b1;
      reload_n = 1'b1;
      watch(2);
      reset = 1'b0;
      watch(1);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      watch(3);
      n_cmp++; if (fire_n !== 1'b1) begin n_err++; $display("FAIL reset_fire_n: got %b expected 1", fire_n); end
      n_cmp++; if (ammo !== 4'd2) begin n_err++; $display("FAIL reset_ammo: got %0d expected 2", ammo); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL reset_empty: got %b expected 0", empty); end
      reset = 1'b0;
      watch(2);
   endtask

   task automatic test_bouncy_press();
      clear_watch();
      for (int i = 0; i < 5; i++) begin
         button_n = (i % 2 == 0) ? 1'b0 : 1'b1;
         watch(2);
      end
      button_n = 1'b0;
      watch(20);
      button_n = 1'b1;
      watch(10);
      n_cmp++; if (falls !== 1) begin n_err++; $display("FAIL bouncy_pulses: got %0d expected 1", falls); end
      n_cmp++; if (lows !== 3) begin n_err++; $display("FAIL bouncy_low_cycles: got %0d expected 3", lows); end
      n_cmp++; if (busys !== 10) begin n_err++; $display("FAIL bouncy_busy_cycles: got %0d expected 10", busys); end
      n_cmp++; if (ammo !== 4'd1) begin n_err++; $display("FAIL bouncy_ammo: got %0d expected 1", ammo); end
      n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL bouncy_empty: got %b expected 0", empty); end
   endtask

   task automatic test_rate_limit();
      do_reset();
      clear_watch();
      press_fire(4);
      watch(4);
      press_fire(10);
      watch(15);
      n_cmp++; if (falls !== 1) begin n_err++; $display("FAIL rate_gap_pulses: got %0d expected 1", falls); end
      n_cmp++; if (ammo !== 4'd1) begin n_err++; $display("FAIL rate_gap_ammo: got %0d expected 1", ammo); end
      clear_watch();
      press_fire(8);
      watch(20);
      n_cmp++; if (falls !== 1) begin n_err++; $display("FAIL rate_after_pulses: got %0d expected 1", falls); end
      n_cmp++; if (lows !== 3) begin n_err++; $display("FAIL rate_after_low_cycles: got %0d expected 3", lows); end
      n_cmp++; if (ammo !== 4'd0) begin n_err++; $display("FAIL rate_after_ammo: got %0d expected 0", ammo); end
      n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL rate_after_empty: got %b expected 1", empty); end
   endtask

   task automatic test_empty_reload();
      clear_watch();
      press_fire(8);
      watch(12);
      n_cmp++; if (falls !== 0) begin n_err++; $display("FAIL empty_pulses: got %0d expected 0", falls); end
      n_cmp++; if (busys !== 0) begin n_err++; $display("FAIL empty_busy_cycles: got %0d expected 0", busys); end
      clear_watch();
      reload_n = 1'b0;
      watch(8);
      reload_n = 1'b1;
      watch(15);
      n_cmp++; if (busys !== 8) begin n_err++; $display("FAIL reload_busy_cycles: got %0d expected 8", busys); end
      n_cmp++; if (ammo !== 4'd2) begin n_err++; $display("FAIL reload_ammo: got %0d expected 2", ammo); end
      n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL reload_empty: got %b expected 0", empty); end
   endtask

   task automatic test_simultaneous();
      press_fire(8);
      watch(20);
      clear_watch();
      button_n = 1'b0;
      reload_n = 1'b0;
      watch(8);
      button_n = 1'b1;
      reload_n = 1'b1;
      watch(20);
      n_cmp++; if (falls !== 1) begin n_err++; $display("FAIL simul_pulses: got %0d expected 1", falls); end
      n_cmp++; if (ammo !== 4'd0) begin n_err++; $display("FAIL simul_ammo: got %0d expected 0", ammo); end
      n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL simul_empty: got %b expected 1", empty); end
      n_cmp++; if (busys !== 10) begin n_err++; $display("FAIL simul_busy_cycles: got %0d expected 10", busys); end
   endtask

   task automatic test_reset_mid_pulse();
      bit seen;
      do_reset();
      seen = 1'b0;
      button_n = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clock);
         if (fire_n === 1'b0) seen = 1'b1;
      end
      n_cmp++;
      if (!seen) begin
         n_err++;
         $display("FAIL midreset_pulse_start: got fire_n %b expected 0 within 20 cycles", fire_n);
      end else begin
         @(negedge clock);
         n_cmp++; if (fire_n !== 1'b0) begin n_err++; $display("FAIL midreset_second_low: got %b expected 0", fire_n); end
         reset = 1'b1;
         button_n = 1'b1;
         @(negedge clock);
         n_cmp++; if (fire_n !== 1'b1) begin n_err++; $display("FAIL midreset_fire_n: got %b expected 1", fire_n); end
         n_cmp++; if (ammo !== 4'd2) begin n_err++; $display("FAIL midreset_ammo: got %0d expected 2", ammo); end
         n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy: got %b expected 0", busy); end
      end
      reset = 1'b0;
      button_n = 1'b1;
      watch(8);
      clear_watch();
      press_fire(8);
      watch(20);
      n_cmp++; if (falls !== 1) begin n_err++; $display("FAIL postreset_pulses: got %0d expected 1", falls); end
      n_cmp++; if (lows !== 3) begin n_err++; $display("FAIL postreset_low_cycles: got %0d expected 3", lows); end
      n_cmp++; if (ammo !== 4'd1) begin n_err++; $display("FAIL postreset_ammo: got %0d expected 1", ammo); end
   endtask

   task automatic test_hold_glitch();
      do_reset();
      clear_watch();
      press_fire(50);
      watch(20);
      n_cmp++; if (falls !== 1) begin n_err++; $display("FAIL hold_pulses: got %0d expected 1", falls); end
      n_cmp++; if (lows !== 3) begin n_err++; $display("FAIL hold_low_cycles: got %0d expected 3", lows); end
      n_cmp++; if (ammo !== 4'd1) begin n_err++; $display("FAIL hold_ammo: got %0d expected 1", ammo); end
      clear_watch();
      press_fire(3);
      watch(20);
      n_cmp++; if (falls !== 0) begin n_err++; $display("FAIL glitch_pulses: got %0d expected 0", falls); end
      n_cmp++; if (ammo !== 4'd1) begin n_err++; $display("FAIL glitch_ammo: got %0d expected 1", ammo); end
   endtask

   initial begin
      test_reset();
      test_bouncy_press();
      test_rate_limit();
      test_empty_reload();
      test_simultaneous();
      test_reset_mid_pulse();
      test_hold_glitch();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
